// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 block function.
//   word_t   : 32-bit state word
//   SIGMA    : standard "expand 32-byte k" constant words, SIGMA[0] first
//   state_t  : block FSM states
//   rotl     : 32-bit rotate-left helper
package chacha_pkg;
  typedef logic [31:0] word_t;

  localparam int DEF_NUM_ROUNDS = 20;

  localparam word_t [3:0] SIGMA = {32'h6b206574, 32'h79622d32,
                                   32'h3320646e, 32'h61707865};

  typedef enum logic [1:0] {LOAD, ROUND, ADD} state_t;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction
endpackage

// File: rtl/chacha_quarter_round.sv
// ChaCha quarter round, purely combinational.
//   a, b, c, d                 : input words
//   a_new, b_new, c_new, d_new : quarter-round results
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_new,
  output word_t b_new,
  output word_t c_new,
  output word_t d_new
);
  word_t a1, b1, c1, d1;

  assign a1    = a + b;
  assign d1    = rotl(d ^ a1, 16);
  assign c1    = c + d1;
  assign b1    = rotl(b ^ c1, 12);
  assign a_new = a1 + b1;
  assign d_new = rotl(d1 ^ a_new, 8);
  assign c_new = c1 + d_new;
  assign b_new = rotl(b1 ^ c_new, 7);
endmodule

// File: rtl/chacha_block_function.sv
// ChaCha20 block function, free-running: LOAD (1) -> ROUND (NUM_ROUNDS) -> ADD (1).
//   clk            : clock, rising edge
//   rst            : synchronous active-low reset
//   Key            : 8 key words, Key[0] first
//   Nonce          : 3 nonce words, Nonce[0] first
//   Block          : block counter word (supplied by host)
//   Constant       : 4 constant words (normally SIGMA)
//   MatrixOut      : keystream state [row][col], held until next block
//   blocksproduced : completed block count (wraps)
//   serial_enable  : one-cycle strobe, MatrixOut holds a new block
module chacha_block_function
  import chacha_pkg::*;
#(
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  word_t [0:7]      Key,
  input  word_t [2:0]      Nonce,
  input  word_t            Block,
  input  word_t [3:0]      Constant,
  output word_t [3:0][3:0] MatrixOut,
  output word_t            blocksproduced,
  output logic             serial_enable
);
  localparam int RCW = (NUM_ROUNDS > 2) ? $clog2(NUM_ROUNDS) : 1;

  state_t           state, state_n;
  logic [RCW-1:0]   rc;
  logic             last_round;
  logic             blockready;

  word_t [3:0][3:0] chachatoQround;  // original state, added back in ADD
  word_t [3:0][3:0] work;
  word_t [3:0][3:0] init;
  word_t [3:0][3:0] nxt;
  word_t [3:0][3:0] sum;

  // Quarter-round operands and results, one set per lane.
  word_t [3:0]      qa, qb, qc, qd;
  word_t [3:0]      qa_n, qb_n, qc_n, qd_n;
  // Column offset per row: 0 for column rounds, row index for diagonal rounds.
  logic  [1:0]      o1, o2, o3;
  logic  [3:0][1:0] cb, cc, cd;

  assign last_round    = (rc == RCW'(NUM_ROUNDS - 1));
  assign serial_enable = blockready;

  // Round 1 (rc=0) is a column round, so odd rc selects diagonals.
  assign o1 = rc[0] ? 2'd1 : 2'd0;
  assign o2 = rc[0] ? 2'd2 : 2'd0;
  assign o3 = rc[0] ? 2'd3 : 2'd0;

  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD:    state_n = ROUND;
      ROUND:   if (last_round) state_n = ADD;
      ADD:     state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_comb begin
    init = '0;
    for (int i = 0; i < 4; i++) begin
      init[0][i] = Constant[i];
      init[1][i] = Key[i];
      init[2][i] = Key[i + 4];
    end
    init[3][0] = Block;
    init[3][1] = Nonce[0];
    init[3][2] = Nonce[1];
    init[3][3] = Nonce[2];
  end

  always_comb begin
    cb = '0;
    cc = '0;
    cd = '0;
    for (int k = 0; k < 4; k++) begin
      cb[k] = 2'(k) + o1;
      cc[k] = 2'(k) + o2;
      cd[k] = 2'(k) + o3;
    end
  end

  always_comb begin
    qa = '0;
    qb = '0;
    qc = '0;
    qd = '0;
    for (int k = 0; k < 4; k++) begin
      qa[k] = work[0][k];
      qb[k] = work[1][cb[k]];
      qc[k] = work[2][cc[k]];
      qd[k] = work[3][cd[k]];
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_qr
    chacha_quarter_round u_qr (
      .a     (qa[k]),
      .b     (qb[k]),
      .c     (qc[k]),
      .d     (qd[k]),
      .a_new (qa_n[k]),
      .b_new (qb_n[k]),
      .c_new (qc_n[k]),
      .d_new (qd_n[k])
    );
  end

  // Results go back to the same positions they were taken from.
  always_comb begin
    nxt = work;
    for (int k = 0; k < 4; k++) begin
      nxt[0][k]     = qa_n[k];
      nxt[1][cb[k]] = qb_n[k];
      nxt[2][cc[k]] = qc_n[k];
      nxt[3][cd[k]] = qd_n[k];
    end
  end

  always_comb begin
    sum = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sum[r][c] = work[r][c] + chachatoQround[r][c];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rc             <= '0;
      chachatoQround <= '0;
      work           <= '0;
      MatrixOut      <= '0;
      blocksproduced <= '0;
      blockready     <= 1'b0;
    end else begin
      blockready <= (state == ADD);
      case (state)
        LOAD: begin
          chachatoQround <= init;
          work           <= init;
          rc             <= '0;
        end
        ROUND: begin
          work <= nxt;
          rc   <= rc + 1'b1;
        end
        ADD: begin
          MatrixOut      <= sum;
          blocksproduced <= blocksproduced + 32'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_block_function.sv
module tb_chacha_block_function;
  import chacha_pkg::*;

  localparam int NR = 20;

  typedef word_t [0:7]      k8_t;
  typedef word_t [2:0]      n3_t;
  typedef word_t [3:0]      c4_t;
  typedef word_t [3:0][3:0] mat_t;
  typedef word_t st_t [16];

  typedef struct {
    k8_t   key;
    n3_t   nonce;
    word_t blk;
    c4_t   cons;
    mat_t  exp;
  } vec_t;

  logic  clk;
  logic  rst;
  k8_t   Key;
  n3_t   Nonce;
  word_t Block;
  c4_t   Constant;
  mat_t  MatrixOut;
  word_t blocksproduced;
  logic  serial_enable;

  int vectors    = 0;
  int miscompares = 0;

  chacha_block_function #(.NUM_ROUNDS(NR)) dut (
    .clk            (clk),
    .rst            (rst),
    .Key            (Key),
    .Nonce          (Nonce),
    .Block          (Block),
    .Constant       (Constant),
    .MatrixOut      (MatrixOut),
    .blocksproduced (blocksproduced),
    .serial_enable  (serial_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RFC 8439 block function on a flat 16-word state.
  function automatic word_t rl(input word_t v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic st_t qr(input st_t x, input int a, input int b, input int c, input int d);
    x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
    x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
    x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
    x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
    return x;
  endfunction

  function automatic mat_t model(input k8_t k, input n3_t n, input word_t b, input c4_t c);
    st_t s, x;
    mat_t m;
    for (int i = 0; i < 4; i++) begin
      s[i]     = c[i];
      s[4 + i] = k[i];
      s[8 + i] = k[4 + i];
    end
    s[12] = b; s[13] = n[0]; s[14] = n[1]; s[15] = n[2];
    x = s;
    for (int r = 0; r < NR / 2; r++) begin
      x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13);
      x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
      x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
    end
    m = '0;
    for (int i = 0; i < 16; i++) m[i / 4][i % 4] = x[i] + s[i];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_mat(input string nm, input mat_t act, input mat_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Wait for the strobe; n = clock edges consumed. Bounded.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!serial_enable && n < 60);
    if (!serial_enable) begin
      vectors++;
      miscompares++;
      $display("FAIL strobe_timeout: got no strobe after %0d cycles want strobe", n);
    end
  endtask

  task automatic apply(input vec_t v);
    Key = v.key; Nonce = v.nonce; Block = v.blk; Constant = v.cons;
  endtask

  vec_t rfc, zero;
  vec_t tbl[6];
  int   n;
  int   exp_bp;
  int   strobes;
  mat_t zm;
  logic all_ok;
  logic [3:0] pn;
  word_t pw;

  initial begin
    // RFC 8439 2.3.2 vector with published result.
    for (int i = 0; i < 8; i++)
      rfc.key[i] = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
    rfc.nonce = '0;
    rfc.nonce[0] = 32'h09000000;
    rfc.nonce[1] = 32'h4a000000;
    rfc.blk  = 32'h00000001;
    rfc.cons = SIGMA;
    rfc.exp[0][0] = 32'he4e7f110; rfc.exp[0][1] = 32'h15593bd1;
    rfc.exp[0][2] = 32'h1fdd0f50; rfc.exp[0][3] = 32'hc47120a3;
    rfc.exp[1][0] = 32'hc7f4d1c7; rfc.exp[1][1] = 32'h0368c033;
    rfc.exp[1][2] = 32'h9aaa2204; rfc.exp[1][3] = 32'h4e6cd4c3;
    rfc.exp[2][0] = 32'h466482d2; rfc.exp[2][1] = 32'h09aa9f07;
    rfc.exp[2][2] = 32'h05d7c214; rfc.exp[2][3] = 32'ha2028bd9;
    rfc.exp[3][0] = 32'hd19c12b5; rfc.exp[3][1] = 32'hb94e16de;
    rfc.exp[3][2] = 32'he883d0cb; rfc.exp[3][3] = 32'h4e3c50a2;

    zero.key = '0; zero.nonce = '0; zero.blk = '0; zero.cons = '0; zero.exp = '0;
    zm = '0;

    tbl[0] = rfc;
    tbl[1] = zero;
    for (int v = 2; v < 6; v++) begin
      for (int i = 0; i < 8; i++) tbl[v].key[i] = $urandom;
      for (int i = 0; i < 3; i++) tbl[v].nonce[i] = $urandom;
      for (int i = 0; i < 4; i++) tbl[v].cons[i] = (v == 2) ? SIGMA[i] : $urandom;
      tbl[v].blk = $urandom;
      tbl[v].exp = model(tbl[v].key, tbl[v].nonce, tbl[v].blk, tbl[v].cons);
    end

    // Reset state
    rst = 1'b0;
    apply(rfc);
    repeat (3) @(posedge clk);
    #1;
    chk_mat("reset_matrix", MatrixOut, zm);
    chk("reset_count", blocksproduced, 32'd0);
    chk("reset_strobe", {31'd0, serial_enable}, 32'd0);
    chk_mat("reset_state", dut.chachatoQround, zm);

    // First block after reset release: RFC vector, 22-cycle latency
    rst = 1'b1;
    exp_bp = 0;
    wait_strobe(n);
    chk("rfc_latency", n, 32'd22);
    chk_mat("rfc_matrix", MatrixOut, rfc.exp);
    chk_mat("rfc_model", MatrixOut, model(rfc.key, rfc.nonce, rfc.blk, rfc.cons));
    exp_bp++;
    chk("rfc_count", blocksproduced, exp_bp);
    chk("blockready", {31'd0, dut.blockready}, 32'd1);
    @(posedge clk); #1;
    chk("strobe_width", {31'd0, serial_enable}, 32'd0);

    // Inputs changed mid-ROUND: current block keeps old inputs
    repeat (4) @(posedge clk);
    #1;
    apply(zero);
    wait_strobe(n);
    chk("midchg_latency", n, 32'd17);
    chk_mat("midchg_matrix", MatrixOut, rfc.exp);
    exp_bp++;
    chk("midchg_count", blocksproduced, exp_bp);
    wait_strobe(n);
    chk("zero_latency", n, 32'd22);
    chk_mat("zero_matrix", MatrixOut, zm);
    exp_bp++;
    chk("zero_count", blocksproduced, exp_bp);

    // Continuous table run: strobes 22 apart, counter increments
    for (int v = 0; v < 6; v++) begin
      apply(tbl[v]);
      wait_strobe(n);
      chk($sformatf("tbl%0d_period", v), n, 32'd22);
      chk_mat($sformatf("tbl%0d_matrix", v), MatrixOut, tbl[v].exp);
      exp_bp++;
      chk($sformatf("tbl%0d_count", v), blocksproduced, exp_bp);
    end

    // Pattern sweep: every input word = {8{p}}
    strobes = 0;
    for (int p = 0; p < 16; p++) begin
      pn = 4'(p);
      pw = {8{pn}};
      for (int i = 0; i < 8; i++) Key[i] = pw;
      for (int i = 0; i < 3; i++) Nonce[i] = pw;
      for (int i = 0; i < 4; i++) Constant[i] = pw;
      Block = pw;
      @(posedge clk); #1;
      all_ok = 1'b1;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (dut.chachatoQround[r][c] !== pw) all_ok = 1'b0;
      chk($sformatf("pat%0d_load", p), {31'd0, all_ok}, 32'd1);
      wait_strobe(n);
      if (serial_enable) strobes++;
      chk($sformatf("pat%0d_period", p), n, 32'd21);
      chk_mat($sformatf("pat%0d_matrix", p), MatrixOut, model(Key, Nonce, Block, Constant));
      exp_bp++;
      chk($sformatf("pat%0d_count", p), blocksproduced, exp_bp);
    end
    chk("pat_strobes", strobes, 32'd16);

    // Reset mid-ROUND: everything clears, no strobe, restart latency 22
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_mat("midrst_matrix", MatrixOut, zm);
    chk("midrst_count", blocksproduced, 32'd0);
    chk("midrst_strobe", {31'd0, serial_enable}, 32'd0);
    chk_mat("midrst_state", dut.chachatoQround, zm);
    strobes = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (serial_enable) strobes++;
    end
    chk("midrst_nostrobe", strobes, 32'd0);
    rst = 1'b1;
    wait_strobe(n);
    chk("midrst_latency", n, 32'd22);
    chk_mat("midrst_result", MatrixOut, model(Key, Nonce, Block, Constant));
    chk("midrst_count1", blocksproduced, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
